// File: rtl/sort_result_unloader_if.sv
// Valid/ready output stream of the sort result unloader.
interface sort_result_unloader_if #(
   parameter int unsigned word_size = 4
);
   logic [word_size-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/sort_result_unloader.sv
// Drains N sorted words from the bubble-sort datapath onto a valid/ready stream.
// Define UNLOAD_ORDER_CHECK_EN to build the non-decreasing order checker (order_err_o).
module sort_result_unloader #(
   parameter int unsigned word_size = 4,
   parameter int unsigned N         = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [word_size-1:0] sort_data_i,
   output logic                 snd_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 order_err_o,
   sort_result_unloader_if.master stream
);
   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CAPT, SEND, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [word_size-1:0] data_q, data_d;
   logic                 last_q, last_d;
`ifdef UNLOAD_ORDER_CHECK_EN
   logic [word_size-1:0] prev_q, prev_d;
   logic                 err_q, err_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
`ifdef UNLOAD_ORDER_CHECK_EN
         prev_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         last_q  <= last_d;
`ifdef UNLOAD_ORDER_CHECK_EN
         prev_q  <= prev_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      data_d           = data_q;
      last_d           = last_q;
`ifdef UNLOAD_ORDER_CHECK_EN
      prev_d           = prev_q;
      err_d            = err_q;
`endif
      snd_o            = 1'b0;
      busy_o           = 1'b1;
      done_o           = 1'b0;
      stream.out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               state_d = CAPT;
               cnt_d   = '0;
`ifdef UNLOAD_ORDER_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         CAPT: begin
            data_d  = sort_data_i;
            cnt_d   = cnt_q + CW'(1);
            last_d  = ((cnt_q + CW'(1)) == CW'(N));
            state_d = SEND;
`ifdef UNLOAD_ORDER_CHECK_EN
            if ((cnt_q != '0) && (sort_data_i < prev_q))
               err_d = 1'b1;
            prev_d  = sort_data_i;
`endif
         end
         SEND: begin
            // Gated by rst so the sorter is never shifted in the reset cycle.
            stream.out_valid = ~rst;
            if (stream.out_ready && !rst) begin
               snd_o   = 1'b1;
               state_d = last_q ? DONE : CAPT;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign stream.out_data = data_q;
   assign stream.out_last = last_q;
`ifdef UNLOAD_ORDER_CHECK_EN
   assign order_err_o = err_q;
`else
   assign order_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sort_result_unloader.sv
// Directed bench for sort_result_unloader: N=8 block tests plus an N=1 instance.
module tb_sort_result_unloader;
   localparam int N = 8;
`ifdef UNLOAD_ORDER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      logic [7:0][3:0] w;
      int stall_beat;
      int stall_len;
      int restart_beat;
      int err_beat;
      int exp_done;
   } vec_t;

   logic clk = 1'b0;
   logic rst, start, snd, busy, done, order_err;
   logic [3:0] sort_data;
   logic start1, snd1, busy1, done1, order_err1;
   logic [3:0] sort_data1;

   int n_cmp = 0;
   int n_bad = 0;
   int snd_cnt = 0;
   int snd1_cnt = 0;
   int base = 0;
   logic [7:0][3:0] cur_words = '0;

   always #5 clk = ~clk;

   sort_result_unloader_if #(.word_size(4)) u_if ();
   sort_result_unloader_if #(.word_size(4)) u_if1 ();

   sort_result_unloader #(.word_size(4), .N(8)) dut (
      .clk(clk), .rst(rst), .start_i(start), .sort_data_i(sort_data),
      .snd_o(snd), .busy_o(busy), .done_o(done), .order_err_o(order_err),
      .stream(u_if.master));

   sort_result_unloader #(.word_size(4), .N(1)) dut1 (
      .clk(clk), .rst(rst), .start_i(start1), .sort_data_i(sort_data1),
      .snd_o(snd1), .busy_o(busy1), .done_o(done1), .order_err_o(order_err1),
      .stream(u_if1.master));

   // Sorter model: head word advances on every snd pulse.
   always @(posedge clk) begin
      if (snd)  snd_cnt  <= snd_cnt + 1;
      if (snd1) snd1_cnt <= snd1_cnt + 1;
   end

   always_comb begin
      int k;
      k = snd_cnt - base;
      sort_data  = (k >= 0 && k < 8) ? cur_words[k[2:0]] : 4'h0;
      sort_data1 = (snd1_cnt == 0) ? 4'hA : 4'h0;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_block(input vec_t v);
      int beat, stall_ctr, first_valid, done_cyc, snd0;
      beat = 0; stall_ctr = 0; first_valid = -1; done_cyc = -1;
      cur_words = v.w;
      base = snd_cnt;
      snd0 = snd_cnt;
      start = 1'b1;
      u_if.out_ready = 1'b1;
      for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
         @(posedge clk); #1;
         start = (v.restart_beat >= 0 && beat == v.restart_beat && u_if.out_valid);
         if (u_if.out_valid && beat == v.stall_beat && stall_ctr < v.stall_len) begin
            u_if.out_ready = 1'b0;
            stall_ctr++;
         end else begin
            u_if.out_ready = 1'b1;
         end
         #1;
         check("busy", busy, 1);
         if (u_if.out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            check("beat_in_range", int'(beat < N), 1);
            if (beat < N) check("out_data", u_if.out_data, v.w[beat]);
            check("out_last", u_if.out_last, int'(beat == N - 1));
            check("snd", snd, u_if.out_ready);
            check("order_err", order_err,
                  int'(CHK && v.err_beat >= 0 && beat >= v.err_beat));
            if (u_if.out_ready) beat++;
         end else begin
            check("snd_no_valid", snd, 0);
         end
         if (done) done_cyc = cyc;
      end
      start = 1'b0;
      check("first_valid", first_valid, 2);
      check("done_cycle", done_cyc, v.exp_done);
      check("beats", beat, N);
      check("snd_count", snd_cnt - snd0, N);
      check("order_err_end", order_err, int'(CHK && v.err_beat >= 0));
      @(posedge clk); #2;
      check("done_pulse", done, 0);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      vec_t vecs[5];
      int beat, dc, beats1;

      vecs[0] = '{w: {4'h8,4'h7,4'h6,4'h5,4'h4,4'h3,4'h2,4'h1},
                  stall_beat: -1, stall_len: 0, restart_beat: -1, err_beat: -1, exp_done: 17};
      vecs[1] = '{w: {4'h8,4'h7,4'h6,4'h5,4'h4,4'h3,4'h2,4'h1},
                  stall_beat: 3, stall_len: 3, restart_beat: -1, err_beat: -1, exp_done: 20};
      vecs[2] = '{w: {4'h9,4'h8,4'h7,4'h6,4'h2,4'h5,4'h5,4'h3},
                  stall_beat: -1, stall_len: 0, restart_beat: -1, err_beat: 3, exp_done: 17};
      vecs[3] = '{w: {4'h8,4'h7,4'h6,4'h5,4'h4,4'h3,4'h2,4'h1},
                  stall_beat: -1, stall_len: 0, restart_beat: 2, err_beat: -1, exp_done: 17};
      vecs[4] = '{w: {4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7,4'h8},
                  stall_beat: -1, stall_len: 0, restart_beat: -1, err_beat: 1, exp_done: 17};

      rst = 1'b1; start = 1'b0; start1 = 1'b0;
      u_if.out_ready = 1'b1; u_if1.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("rst_valid", u_if.out_valid, 0);
      check("rst_data", u_if.out_data, 0);
      check("rst_last", u_if.out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", order_err, 0);
      check("rst_snd", snd, 0);
      check("rst_valid_n1", u_if1.out_valid, 0);
      check("rst_busy_n1", busy1, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_block(vecs[i]);

      // Reset while the fifth word is being offered.
      cur_words = vecs[0].w;
      base = snd_cnt;
      start = 1'b1;
      u_if.out_ready = 1'b1;
      beat = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (u_if.out_valid) begin
            if (beat == 4) break;
            beat++;
         end
      end
      check("rst_at_beat", beat, 4);
      check("rst_beat_data", u_if.out_data, 5);
      rst = 1'b1;
      #1;
      check("snd_in_rst_cycle", snd, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("post_rst_valid", u_if.out_valid, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_snd", snd, 0);
      check("post_rst_data", u_if.out_data, 0);
      check("post_rst_last", u_if.out_last, 0);
      check("post_rst_snd_count", snd_cnt - base, 4);
      run_block(vecs[0]);

      // N=1 instance: single word 0xA.
      beats1 = 0; dc = -1;
      start1 = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk); #1;
         start1 = 1'b0;
         #1;
         if (u_if1.out_valid) begin
            if (beats1 == 0) check("n1_first_valid", cyc, 2);
            beats1++;
            check("n1_data", u_if1.out_data, 10);
            check("n1_last", u_if1.out_last, 1);
         end
         if (done1 && dc < 0) dc = cyc;
      end
      check("n1_beats", beats1, 1);
      check("n1_snd_count", snd1_cnt, 1);
      check("n1_done_cycle", dc, 3);
      check("n1_err", order_err1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
